// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: region selects, MMIO offsets,
// STATUS bit positions and the UART transmit state encoding.
package dmem_pkg;

  localparam logic [3:0] REGION_RAM  = 4'h0;
  localparam logic [3:0] REGION_MMIO = 4'h1;

  localparam logic [1:0] OFS_CYCLE   = 2'd0;
  localparam logic [1:0] OFS_TX_DATA = 2'd1;
  localparam logic [1:0] OFS_STATUS  = 2'd2;
  localparam logic [1:0] OFS_GPIO    = 2'd3;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_FULL_BIT = 1;
  localparam int STATUS_OVF_BIT  = 2;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: 8N1 serializer fed from a FIFO head; o_pop is high in the cycle a byte is taken.
// state      | meaning
// UART_IDLE  | line high, waiting for a byte
// UART_START | start bit (0)
// UART_DATA  | data bits, LSB first
// UART_STOP  | stop bit (1); chains straight into START when another byte waits
module uart_tx_fsm
  import dmem_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_pop,
  output logic       o_busy,
  output logic       o_tx
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_e   r_state, w_state;
  logic [BW-1:0] r_baud, w_baud;
  logic [2:0]    r_bit, w_bit;
  logic [7:0]    r_shift, w_shift;
  logic          w_tick;

  assign w_tick = (r_baud == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= UART_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state;
      r_baud  <= w_baud;
      r_bit   <= w_bit;
      r_shift <= w_shift;
    end
  end

  always_comb begin
    w_state = r_state;
    w_baud  = w_tick ? BAUD_LAST : r_baud - 1'b1;
    w_bit   = r_bit;
    w_shift = r_shift;
    o_pop   = 1'b0;
    case (r_state)
      UART_IDLE: begin
        w_baud = BAUD_LAST;
        if (i_valid) begin
          o_pop   = 1'b1;
          w_shift = i_data;
          w_state = UART_START;
        end
      end
      UART_START: begin
        if (w_tick) begin
          w_bit   = '0;
          w_state = UART_DATA;
        end
      end
      UART_DATA: begin
        if (w_tick) begin
          w_shift = {1'b0, r_shift[7:1]};
          w_bit   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state = UART_STOP;
        end
      end
      UART_STOP: begin
        if (w_tick) begin
          // Chain the next frame with no idle gap when the FIFO still holds data.
          if (i_valid) begin
            o_pop   = 1'b1;
            w_shift = i_data;
            w_state = UART_START;
          end else begin
            w_state = UART_IDLE;
          end
        end
      end
      default: w_state = UART_IDLE;
    endcase
  end

  always_comb begin
    o_tx = 1'b1;
    case (r_state)
      UART_START: o_tx = 1'b0;
      UART_DATA:  o_tx = r_shift[0];
      default:    o_tx = 1'b1;
    endcase
  end

  assign o_busy = (r_state != UART_IDLE);

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: CPU data-port responder with a word RAM and an MMIO window (CYCLE, TX_DATA, STATUS, GPIO).
// Define DMEM_UART_EN to build the UART TX FIFO and transmitter; otherwise uart_tx idles high.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int    DEPTH        = 1024,
  parameter string INIT_FILE    = "",
  parameter int    CLKS_PER_BIT = 868,
  parameter int    FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic [31:0] gpio_out,
  output logic        uart_tx
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_cycle;
  logic [31:0]   r_gpio;
  logic [3:0]    w_region;
  logic [1:0]    w_ofs;
  logic [AW-1:0] w_widx;
  logic          w_sel_ram;
  logic          w_sel_mmio;
  logic          w_wr_ram;
  logic          w_wr_mmio;
  logic [31:0]   w_status;
  logic          w_unused;

  assign w_region   = mem_addr[31:28];
  assign w_ofs      = mem_addr[3:2];
  assign w_widx     = mem_addr[AW+1:2];
  assign w_sel_ram  = (w_region == REGION_RAM);
  assign w_sel_mmio = (w_region == REGION_MMIO);
  assign w_wr_ram   = mem_write && w_sel_ram;
  assign w_wr_mmio  = mem_write && w_sel_mmio;
  // Byte lane and the MMIO page bits are don't-care by design.
  assign w_unused   = ^{mem_addr[27:4], mem_addr[1:0]};

  always_ff @(posedge clk) begin
    if (w_wr_ram) r_mem[w_widx] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle <= '0;
      r_gpio  <= '0;
    end else begin
      if (w_wr_mmio && (w_ofs == OFS_CYCLE)) r_cycle <= mem_wdata;
      else                                   r_cycle <= r_cycle + 32'd1;
      if (w_wr_mmio && (w_ofs == OFS_GPIO))  r_gpio  <= mem_wdata;
    end
  end

`ifdef DMEM_UART_EN
  localparam int PW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic          r_ovf;
  logic          w_empty;
  logic          w_full;
  logic          w_push_req;
  logic          w_push;
  logic          w_pop;
  logic          w_fsm_busy;

  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[PW-1] != r_rptr[PW-1]) && (r_wptr[PW-2:0] == r_rptr[PW-2:0]);
  assign w_push_req = w_wr_mmio && (w_ofs == OFS_TX_DATA);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign w_push     = w_push_req && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr[PW-2:0]] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_wr_mmio && (w_ofs == OFS_STATUS)) r_ovf <= 1'b0;
      else if (w_push_req && !w_push)         r_ovf <= 1'b1;
    end
  end

  uart_tx_fsm #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .reset  (reset),
    .i_valid(!w_empty),
    .i_data (r_fifo[r_rptr[PW-2:0]]),
    .o_pop  (w_pop),
    .o_busy (w_fsm_busy),
    .o_tx   (uart_tx)
  );

  always_comb begin
    w_status                  = '0;
    w_status[STATUS_BUSY_BIT] = w_fsm_busy || !w_empty;
    w_status[STATUS_FULL_BIT] = w_full;
    w_status[STATUS_OVF_BIT]  = r_ovf;
  end
`else
  localparam int unused_cfg = CLKS_PER_BIT + FIFO_DEPTH;

  assign w_status = '0;
  assign uart_tx  = 1'b1;
`endif

  always_comb begin
    mem_rdata = '0;
    if (w_sel_ram) begin
      mem_rdata = r_mem[w_widx];
    end else if (w_sel_mmio) begin
      case (w_ofs)
        OFS_CYCLE:  mem_rdata = r_cycle;
        OFS_STATUS: mem_rdata = w_status;
        OFS_GPIO:   mem_rdata = r_gpio;
        default:    mem_rdata = '0;
      endcase
    end
  end

  assign gpio_out = r_gpio;

endmodule
